// File: rtl/vtp_fail_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vtp_fail_pkg
// Description : Shared types, constants and round-robin pick helper for the
//               VTP translation-failure log.
// Revision    : 1.0 - initial release
// ============================================================================
package vtp_fail_pkg;

  // Byte offset of a cache line inside a VA.
  localparam int VTP_FAIL_LINE_OFFSET = 6;
  localparam int VTP_FAIL_MAX_PORTS   = 16;
  localparam int VTP_FAIL_PORT_W      = 4;
  localparam int VTP_FAIL_LINE_W      = 64 - VTP_FAIL_LINE_OFFSET;

  // Sized for the widest legal configuration; narrower configs zero-extend.
  typedef struct packed {
    logic [VTP_FAIL_PORT_W-1:0] port;
    logic                       is_write;
    logic [VTP_FAIL_LINE_W-1:0] line_addr;
  } t_vtp_fail_entry;

  // One-hot grant: first valid port at or above ptr, wrapping at num_ports-1.
  function automatic logic [VTP_FAIL_MAX_PORTS-1:0] vtp_fail_rr_pick(
    input logic [VTP_FAIL_MAX_PORTS-1:0] valid,
    input logic [VTP_FAIL_PORT_W-1:0]    ptr,
    input int                            num_ports
  );
    logic [VTP_FAIL_MAX_PORTS-1:0] grant;
    int idx;
    grant = '0;
    for (int k = 0; k < VTP_FAIL_MAX_PORTS; k++) begin
      idx = int'(ptr) + k;
      if (idx >= num_ports) idx = idx - num_ports;
      if ((k < num_ports) && (grant == '0) && valid[idx[3:0]]) grant[idx[3:0]] = 1'b1;
    end
    return grant;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vtp_fail_event_arbiter_log_fifo.sv
`default_nettype none
// ============================================================================
// Module      : vtp_fail_log_fifo
// Description : Synchronous show-ahead FIFO of failure entries with
//               registered head, occupancy, full and empty.
// Revision    : 1.0 - initial release
// ============================================================================
module vtp_fail_log_fifo
  import vtp_fail_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  t_vtp_fail_entry              push_data,
  input  logic                         pop,
  output t_vtp_fail_entry              head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  t_vtp_fail_entry mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   rd_ptr_next;
  logic [CW-1:0]   count_next;
  logic            do_push;
  logic            do_pop;

  assign full        = (count == CW'(DEPTH));
  assign empty       = (count == '0);
  assign do_push     = push & ~full;
  assign do_pop      = pop & ~empty;
  assign rd_ptr_next = rd_ptr + AW'(do_pop);
  assign count_next  = count + CW'(do_push) - CW'(do_pop);

  // Entry storage; contents are qualified by count so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers, occupancy and the registered head; a push into a FIFO that is
  // empty after this cycle's pop bypasses storage straight into the head.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr_next;
      count  <= count_next;
      if (count_next == '0)
        head <= '0;
      else if (do_push && (count == CW'(do_pop)))
        head <= push_data;
      else
        head <= mem[rd_ptr_next];
    end
  end

endmodule
`default_nettype wire

// File: rtl/vtp_fail_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vtp_fail_event_arbiter
// Description : Round-robin merge of per-port VTP failure events into one
//               show-ahead log, with saturating read/write/drop counters.
// Revision    : 1.0 - initial release
// ============================================================================
module vtp_fail_event_arbiter
  import vtp_fail_pkg::*;
#(
  parameter int NUM_PORTS       = 4,
  parameter int FIFO_DEPTH      = 8,
  parameter int LINE_ADDR_WIDTH = 58,
  parameter int CNT_WIDTH       = 16,
  parameter int LOSSY           = 0,
  localparam int PORT_W         = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  localparam int COUNT_W        = $clog2(FIFO_DEPTH+1)
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [NUM_PORTS-1:0]                      fail_valid,
  input  logic [NUM_PORTS-1:0]                      fail_is_write,
  input  logic [NUM_PORTS-1:0][LINE_ADDR_WIDTH-1:0] fail_line_addr,
  output logic [NUM_PORTS-1:0]                      fail_ready,
  output logic                                      log_valid,
  input  logic                                      log_pop,
  output logic [PORT_W-1:0]                         log_port,
  output logic                                      log_is_write,
  output logic [63:0]                               log_va,
  output logic [COUNT_W-1:0]                        log_count,
  output logic [CNT_WIDTH-1:0]                      rd_fail_cnt,
  output logic [CNT_WIDTH-1:0]                      wr_fail_cnt,
  output logic [CNT_WIDTH-1:0]                      drop_cnt
);

  localparam int                SUM_W     = CNT_WIDTH + 5;
  localparam logic [SUM_W-1:0]  CNT_MAX   = {5'b0, {CNT_WIDTH{1'b1}}};
  localparam logic [PORT_W-1:0] LAST_PORT = PORT_W'(NUM_PORTS - 1);

  logic [PORT_W-1:0]             rr_ptr;
  logic [VTP_FAIL_MAX_PORTS-1:0] rr_pick;
  logic [NUM_PORTS-1:0]          grant;
  logic [NUM_PORTS-1:0]          consumed;
  logic [PORT_W-1:0]             grant_idx;
  logic                          can_push;
  logic                          push;
  t_vtp_fail_entry               push_entry;
  t_vtp_fail_entry               head;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic [4:0]                    rd_inc;
  logic [4:0]                    wr_inc;
  logic [4:0]                    drop_inc;
  logic                          unused_bits;

  // Add with a widened sum and clamp at all-ones.
  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] cnt,
                                                   input logic [4:0] inc);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(cnt) + SUM_W'(inc);
    return (sum > CNT_MAX) ? CNT_MAX[CNT_WIDTH-1:0] : sum[CNT_WIDTH-1:0];
  endfunction

  // Space is judged on pre-pop occupancy, so a same-cycle pop never frees room.
  assign can_push = ~fifo_full;
  assign rr_pick  = vtp_fail_rr_pick(VTP_FAIL_MAX_PORTS'(fail_valid),
                                     VTP_FAIL_PORT_W'(rr_ptr), NUM_PORTS);
  assign grant    = rr_pick[NUM_PORTS-1:0] & {NUM_PORTS{can_push & ~reset}};
  assign push     = |grant;
  assign consumed = fail_valid & fail_ready;

  generate
    if (LOSSY != 0) begin : g_lossy
      assign fail_ready = {NUM_PORTS{~reset}};
    end else begin : g_lossless
      assign fail_ready = grant;
    end
  endgenerate

  // Encode the one-hot grant and select its payload.
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant[i]) grant_idx = PORT_W'(i);
    end
    push_entry           = '0;
    push_entry.port      = VTP_FAIL_PORT_W'(grant_idx);
    push_entry.is_write  = fail_is_write[grant_idx];
    push_entry.line_addr = VTP_FAIL_LINE_W'(fail_line_addr[grant_idx]);
  end

  // Per-cycle counter increments; everything consumed but not logged is a drop.
  always_comb begin
    rd_inc = '0;
    wr_inc = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (consumed[i]) begin
        if (fail_is_write[i]) wr_inc = wr_inc + 5'd1;
        else                  rd_inc = rd_inc + 5'd1;
      end
    end
    drop_inc = rd_inc + wr_inc - 5'(push);
  end

  // Round-robin pointer moves just past the winner.
  always_ff @(posedge clk) begin
    if (reset)
      rr_ptr <= '0;
    else if (push)
      rr_ptr <= (grant_idx == LAST_PORT) ? '0 : grant_idx + 1'b1;
  end

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_fail_cnt <= '0;
      wr_fail_cnt <= '0;
      drop_cnt    <= '0;
    end else begin
      rd_fail_cnt <= sat_add(rd_fail_cnt, rd_inc);
      wr_fail_cnt <= sat_add(wr_fail_cnt, wr_inc);
      drop_cnt    <= sat_add(drop_cnt, drop_inc);
    end
  end

  vtp_fail_log_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_log_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (log_pop),
    .head      (head),
    .count     (log_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign log_valid    = ~fifo_empty;
  assign log_port     = head.port[PORT_W-1:0];
  assign log_is_write = head.is_write;
  assign log_va       = {head.line_addr, {VTP_FAIL_LINE_OFFSET{1'b0}}};
  assign unused_bits  = ^{rr_pick, head.port};

endmodule
`default_nettype wire

// File: tb/tb_vtp_fail_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vtp_fail_event_arbiter
// Description : Self-checking bench; a lossless instance is tracked by a
//               reference model and scoreboard, a lossy instance by targeted
//               constant checks (full-FIFO drops and counter saturation).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vtp_fail_event_arbiter;

  localparam int NP    = 4;
  localparam int DEPTH = 8;
  localparam int AW    = 58;
  localparam int CW    = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Lossless instance
  logic                   reset0;
  logic [NP-1:0]          valid0, isw0, ready0;
  logic [NP-1:0][AW-1:0]  addr0;
  logic                   lv0, pop0, lw0;
  logic [1:0]             lport0;
  logic [63:0]            lva0;
  logic [3:0]             lcnt0;
  logic [CW-1:0]          rd0, wr0, dr0;

  // Lossy instance
  logic                   reset1;
  logic [NP-1:0]          valid1, isw1, ready1;
  logic [NP-1:0][AW-1:0]  addr1;
  logic                   lv1, pop1, lw1;
  logic [1:0]             lport1;
  logic [63:0]            lva1;
  logic [3:0]             lcnt1;
  logic [CW-1:0]          rd1, wr1, dr1;

  vtp_fail_event_arbiter #(.NUM_PORTS(NP), .FIFO_DEPTH(DEPTH), .LINE_ADDR_WIDTH(AW),
                           .CNT_WIDTH(CW), .LOSSY(0)) dut0 (
    .clk(clk), .reset(reset0), .fail_valid(valid0), .fail_is_write(isw0),
    .fail_line_addr(addr0), .fail_ready(ready0), .log_valid(lv0), .log_pop(pop0),
    .log_port(lport0), .log_is_write(lw0), .log_va(lva0), .log_count(lcnt0),
    .rd_fail_cnt(rd0), .wr_fail_cnt(wr0), .drop_cnt(dr0));

  vtp_fail_event_arbiter #(.NUM_PORTS(NP), .FIFO_DEPTH(DEPTH), .LINE_ADDR_WIDTH(AW),
                           .CNT_WIDTH(CW), .LOSSY(1)) dut1 (
    .clk(clk), .reset(reset1), .fail_valid(valid1), .fail_is_write(isw1),
    .fail_line_addr(addr1), .fail_ready(ready1), .log_valid(lv1), .log_pop(pop1),
    .log_port(lport1), .log_is_write(lw1), .log_va(lva1), .log_count(lcnt1),
    .rd_fail_cnt(rd1), .wr_fail_cnt(wr1), .drop_cnt(dr1));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model of the lossless instance
  typedef struct {
    int          port;
    bit          w;
    logic [63:0] va;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   m_ptr = 0;
  int   m_cnt = 0;
  int   m_rd  = 0;
  int   m_wr  = 0;

  // One clock of the lossless instance: check outputs, predict the grant,
  // then advance the model across the edge.
  task automatic tick0();
    int            g;
    bit            popped;
    bit            w;
    logic [63:0]   va;
    logic [NP-1:0] exp_ready;
    exp_t          e;
    @(negedge clk);
    check("count0", 64'(lcnt0), 64'(m_cnt));
    check("lvalid0", 64'(lv0), 64'(m_cnt > 0));
    check("rdcnt0", 64'(rd0), 64'(m_rd));
    check("wrcnt0", 64'(wr0), 64'(m_wr));
    check("drop0", 64'(dr0), 64'd0);
    if (m_cnt > 0) begin
      check("head_port0", 64'(lport0), 64'(sb[0].port));
      check("head_wr0", 64'(lw0), 64'(sb[0].w));
      check("head_va0", lva0, sb[0].va);
    end
    g = -1;
    if (!reset0 && m_cnt < DEPTH) begin
      for (int k = 0; k < NP; k++) begin
        int p;
        p = (m_ptr + k) % NP;
        if (g < 0 && valid0[p]) g = p;
      end
    end
    exp_ready = (g >= 0) ? NP'(1 << g) : '0;
    check("ready0", 64'(ready0), 64'(exp_ready));
    popped = !reset0 && pop0 && (m_cnt > 0);
    w  = 1'b0;
    va = '0;
    if (g >= 0) begin
      w  = isw0[g];
      va = 64'(addr0[g]) << 6;
    end
    @(posedge clk);
    #1;
    if (reset0) begin
      sb.delete();
      m_cnt = 0; m_ptr = 0; m_rd = 0; m_wr = 0;
    end else begin
      if (popped) void'(sb.pop_front());
      if (g >= 0) begin
        e.port = g; e.w = w; e.va = va;
        sb.push_back(e);
        grant_log.push_back(g);
        m_ptr = (g + 1) % NP;
        if (w) m_wr++; else m_rd++;
      end
      m_cnt = m_cnt + ((g >= 0) ? 1 : 0) - (popped ? 1 : 0);
    end
  endtask

  task automatic reset_pulse0();
    reset0 = 1'b1;
    tick0();
    reset0 = 1'b0;
  endtask

  task automatic step1(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int exp_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

  initial begin
    reset0 = 1'b1; valid0 = '0; isw0 = '0; addr0 = '0; pop0 = 1'b0;
    reset1 = 1'b1; valid1 = '0; isw1 = '0; addr1 = '0; pop1 = 1'b0;

    // ---------------- reset state and single-event latency ----------------
    tick0();
    tick0();
    check("rst_lvalid", 64'(lv0), 64'd0);
    check("rst_count", 64'(lcnt0), 64'd0);
    check("rst_va", lva0, 64'd0);
    check("rst_port", 64'(lport0), 64'd0);
    check("rst_rd", 64'(rd0), 64'd0);
    reset0 = 1'b0;
    repeat (3) tick0();
    valid0    = 4'b0100;
    isw0      = 4'b0000;
    addr0[2]  = 58'h1000;
    tick0();
    valid0 = '0;
    check("first_lvalid", 64'(lv0), 64'd1);
    check("first_port", 64'(lport0), 64'd2);
    check("first_wr", 64'(lw0), 64'd0);
    check("first_va", lva0, 64'h40000);
    check("first_rdcnt", 64'(rd0), 64'd1);
    tick0();
    pop0 = 1'b1;
    tick0();
    pop0 = 1'b0;
    tick0();

    // ---------------- round-robin fairness, continuous pop ----------------
    reset_pulse0();
    grant_log.delete();
    for (int p = 0; p < NP; p++) addr0[p] = AW'(58'h100 + p);
    isw0   = 4'b1010;
    valid0 = 4'b1111;
    pop0   = 1'b1;
    repeat (8) tick0();
    valid0 = '0;
    check("rr_ngrants", 64'(grant_log.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < grant_log.size()) check($sformatf("rr_order%0d", i), 64'(grant_log[i]), 64'(exp_order[i]));
    end
    repeat (2) tick0();
    pop0 = 1'b0;
    tick0();

    // ---------------- backpressure on a full FIFO ----------------
    reset_pulse0();
    grant_log.delete();
    valid0   = 4'b0010;
    isw0     = 4'b0010;
    addr0[1] = 58'h2000;
    repeat (10) tick0();
    check("full_count", 64'(lcnt0), 64'd8);
    check("full_wrcnt", 64'(wr0), 64'd8);
    check("full_ready", 64'(ready0), 64'd0);
    pop0 = 1'b1;
    tick0();
    pop0 = 1'b0;
    tick0();
    check("refill_count", 64'(lcnt0), 64'd8);
    check("refill_wrcnt", 64'(wr0), 64'd9);
    check("refill_drop", 64'(dr0), 64'd0);
    tick0();
    check("refill_ngrants", 64'(grant_log.size()), 64'd9);
    valid0 = '0;

    // ---------------- reset mid-operation ----------------
    reset_pulse0();
    valid0 = 4'b1111;
    isw0   = 4'b0011;
    repeat (5) tick0();
    check("mid_count", 64'(lcnt0), 64'd5);
    reset0 = 1'b1;
    tick0();
    reset0 = 1'b0;
    check("mid_lvalid", 64'(lv0), 64'd0);
    check("mid_count0", 64'(lcnt0), 64'd0);
    check("mid_rd", 64'(rd0), 64'd0);
    check("mid_wr", 64'(wr0), 64'd0);
    grant_log.delete();
    tick0();
    check("mid_first_grant", 64'((grant_log.size() > 0) ? grant_log[0] : -1), 64'd0);
    valid0 = '0;
    pop0   = 1'b1;
    repeat (3) tick0();
    pop0 = 1'b0;
    tick0();

    // ---------------- lossy: drops on a full FIFO ----------------
    step1(2);
    reset1 = 1'b0;
    valid1 = 4'b0001;
    isw1   = 4'b0000;
    step1(8);
    check("lossy_fill", 64'(lcnt1), 64'd8);
    check("lossy_rd", 64'(rd1), 64'd8);
    valid1 = 4'b0111;
    isw1   = 4'b0111;
    @(negedge clk);
    check("lossy_ready", 64'(ready1), 64'hf);
    step1(1);
    valid1 = '0;
    check("lossy_drop", 64'(dr1), 64'd3);
    check("lossy_wr", 64'(wr1), 64'd3);
    check("lossy_rd2", 64'(rd1), 64'd8);
    check("lossy_count", 64'(lcnt1), 64'd8);

    // ---------------- lossy: counter saturation ----------------
    reset1 = 1'b1;
    @(negedge clk);
    check("lossy_rst_ready", 64'(ready1), 64'd0);
    step1(1);
    reset1 = 1'b0;
    valid1 = 4'b1111;
    isw1   = 4'b1111;
    step1(16400);
    check("sat_wr", 64'(wr1), 64'hffff);
    check("sat_drop", 64'(dr1), 64'hffff);
    step1(3);
    check("sat_wr_hold", 64'(wr1), 64'hffff);
    check("sat_rd", 64'(rd1), 64'd0);
    valid1 = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
